// File: rtl/resize_box.sv
// Centred-window crop followed by a 2^SCALE_LOG2 downscale per axis, either by
// decimation or by box averaging, on a valid-only pixel stream.

module resize_box_ch #(
    parameter int DW         = 8,
    parameter int SCALE_LOG2 = 2,
    parameter int H_OUTPUT   = 418,
    parameter int OUT_SHIFT  = 1,
    parameter int XW         = 9
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_mode,
    input  logic                  i_vld,
    input  logic [DW-1:0]         i_pix,
    input  logic [SCALE_LOG2-1:0] i_hx,
    input  logic [SCALE_LOG2-1:0] i_vy,
    input  logic [XW-1:0]         i_x,
    output logic [DW-1:0]         o_pix
);
    localparam int AW = DW + SCALE_LOG2;
    localparam int MW = DW + 2*SCALE_LOG2;
    localparam int SH = 2*SCALE_LOG2 + OUT_SHIFT;

    logic [AW-1:0] hacc;
    logic [AW-1:0] row_sum;
    logic [MW-1:0] line_mem [H_OUTPUT];
    logic [MW-1:0] blk_sum;
    logic          row_end;
    logic          mem_we;

    // hx==0 restarts the row sum, so hacc needs no explicit clear between blocks
    always_comb begin
        row_sum = ((i_hx == '0) ? '0 : hacc) + AW'(i_pix);
        blk_sum = line_mem[i_x] + MW'(row_sum);
        row_end = &i_hx;
        mem_we  = i_vld && i_mode && row_end;
    end

    always_ff @(posedge i_clk) begin
        if (mem_we)
            line_mem[i_x] <= (i_vy == '0) ? MW'(row_sum) : blk_sum;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hacc  <= '0;
            o_pix <= '0;
        end else begin
            o_pix <= '0;
            if (i_vld) begin
                hacc <= row_sum;
                if (!i_mode && i_hx == '0 && i_vy == '0)
                    o_pix <= i_pix >> OUT_SHIFT;
                else if (i_mode && row_end && (&i_vy))
                    o_pix <= DW'(blk_sum >> SH);
            end
        end
    end
endmodule

module resize_box #(
    parameter int H_ACTIVE   = 1920,
    parameter int V_ACTIVE   = 1080,
    parameter int H_OUTPUT   = 418,
    parameter int V_OUTPUT   = 258,
    parameter int SCALE_LOG2 = 2,
    parameter int CH         = 3,
    parameter int DW         = 8,
    parameter int OUT_SHIFT  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic             i_de,
    input  logic [CH*DW-1:0] i_data,
    output logic             o_de,
    output logic [CH*DW-1:0] o_data,
    output logic             o_busy,
    output logic             o_frame_done
);
    localparam int S      = 1 << SCALE_LOG2;
    localparam int H_LEFT = (H_ACTIVE - (H_OUTPUT << SCALE_LOG2)) / 2;
    localparam int V_LEFT = (V_ACTIVE - (V_OUTPUT << SCALE_LOG2)) / 2;
    localparam int HW     = $clog2(H_ACTIVE + 1);
    localparam int VW     = $clog2(V_ACTIVE + 1);
    localparam int XW     = (H_OUTPUT > 1) ? $clog2(H_OUTPUT) : 1;

    localparam logic [HW-1:0] H_LO  = HW'(H_LEFT);
    localparam logic [HW-1:0] H_HI  = HW'(H_LEFT + H_OUTPUT*S);
    localparam logic [HW-1:0] H_MAX = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_LO  = VW'(V_LEFT);
    localparam logic [VW-1:0] V_HI  = VW'(V_LEFT + V_OUTPUT*S);
    localparam logic [VW-1:0] V_MAX = VW'(V_ACTIVE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_TRAN} state_t;

    state_t        state, nxt;
    logic          start_meta, start_sync, start_prev, start_edge;
    logic          mode_r;
    logic [HW-1:0] h_cnt, h_off;
    logic [VW-1:0] v_cnt, v_off;
    logic          h_last, v_last, frame_last, in_win;

    logic                           p1_vld;
    logic [CH-1:0][DW-1:0]          p1_pix;
    logic [SCALE_LOG2-1:0]          p1_hx, p1_vy;
    logic [XW-1:0]                  p1_x;
    logic [CH-1:0][DW-1:0]          o_pix;

    assign start_edge = start_sync & ~start_prev;
    assign h_last     = (h_cnt == H_MAX);
    assign v_last     = (v_cnt == V_MAX);
    assign frame_last = i_de && h_last && v_last;
    assign in_win     = (h_cnt >= H_LO) && (h_cnt < H_HI) && (v_cnt >= V_LO) && (v_cnt < V_HI);
    assign h_off      = h_cnt - H_LO;
    assign v_off      = v_cnt - V_LO;
    assign o_busy     = (state != ST_IDLE);
    assign o_data     = o_pix;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            start_meta <= 1'b0;
            start_sync <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            start_meta <= i_start;
            start_sync <= start_meta;
            start_prev <= start_sync;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (i_de) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            mode_r       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            state        <= nxt;
            o_frame_done <= (state == ST_TRAN) && frame_last;
            if (state == ST_IDLE && start_edge)
                mode_r <= i_mode;
        end
    end

    // WAIT lets the current frame run out so TRAN always spans a whole frame
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: if (start_edge) nxt = ST_WAIT;
            ST_WAIT: if (frame_last) nxt = ST_TRAN;
            ST_TRAN: if (frame_last) nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            p1_vld <= 1'b0;
            p1_pix <= '0;
            p1_hx  <= '0;
            p1_vy  <= '0;
            p1_x   <= '0;
            o_de   <= 1'b0;
        end else begin
            p1_vld <= i_de && (state == ST_TRAN) && in_win;
            p1_pix <= i_data;
            p1_hx  <= h_off[SCALE_LOG2-1:0];
            p1_vy  <= v_off[SCALE_LOG2-1:0];
            p1_x   <= XW'(h_off >> SCALE_LOG2);
            o_de   <= p1_vld && (mode_r ? ((&p1_hx) && (&p1_vy))
                                        : (p1_hx == '0 && p1_vy == '0));
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        resize_box_ch #(
            .DW(DW), .SCALE_LOG2(SCALE_LOG2), .H_OUTPUT(H_OUTPUT),
            .OUT_SHIFT(OUT_SHIFT), .XW(XW)
        ) u_ch (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_mode(mode_r),
            .i_vld (p1_vld),
            .i_pix (p1_pix[c]),
            .i_hx  (p1_hx),
            .i_vy  (p1_vy),
            .i_x   (p1_x),
            .o_pix (o_pix[c])
        );
    end
endmodule

// File: tb/tb_resize_box.sv
// Directed bench for resize_box with a 16x8 source, 3x2 output, 4:1 per axis.

module tb_resize_box;
    localparam int H_ACTIVE = 16, V_ACTIVE = 8, H_OUTPUT = 3, V_OUTPUT = 2;
    localparam int SCALE_LOG2 = 2, CH = 3, DW = 8, OUT_SHIFT = 1;
    localparam int NB = H_ACTIVE * V_ACTIVE;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_start = 1'b0;
    logic             i_mode = 1'b0;
    logic             i_de = 1'b0;
    logic [CH*DW-1:0] i_data = '0;
    logic             o_de;
    logic [CH*DW-1:0] o_data;
    logic             o_busy;
    logic             o_frame_done;

    resize_box #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_OUTPUT(H_OUTPUT), .V_OUTPUT(V_OUTPUT),
        .SCALE_LOG2(SCALE_LOG2), .CH(CH), .DW(DW), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
        .i_de(i_de), .i_data(i_data), .o_de(o_de), .o_data(o_data),
        .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0, n_fail = 0;
    int tb_h = 0, tb_v = 0, cur_h = 0;
    int hist_h[3];
    bit hist_de[3];
    logic [23:0] out_q[$];
    int src_q[$];
    int fd_cnt = 0, lat_err = 0, nz_err = 0;

    logic [23:0] ev_ramp[3]  = '{24'h010101, 24'h030303, 24'h050505};
    logic [23:0] ev_const[3] = '{24'h404040, 24'h404040, 24'h404040};
    int          es_dec[3]   = '{2, 6, 10};
    int          es_avg[3]   = '{5, 9, 13};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // hist[2] after the shift is the input cycle that a 2-cycle-latency output came from
    always @(negedge i_clk) begin
        hist_h[2] = hist_h[1];  hist_h[1] = hist_h[0];  hist_h[0] = cur_h;
        hist_de[2] = hist_de[1]; hist_de[1] = hist_de[0]; hist_de[0] = i_de;
        if (o_de) begin
            out_q.push_back(o_data);
            src_q.push_back(hist_h[2]);
            if (!hist_de[2]) lat_err++;
        end else if (o_data != '0) begin
            nz_err++;
        end
        if (o_frame_done) fd_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, run did not complete");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        i_de = 1'b0;
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic beat(input bit ramp);
        i_de   = 1'b1;
        cur_h  = tb_h;
        i_data = ramp ? {3{8'(tb_h)}} : 24'h808080;
        @(posedge i_clk);
        #1;
        i_de = 1'b0;
        if (tb_h == H_ACTIVE - 1) begin
            tb_h = 0;
            tb_v = (tb_v == V_ACTIVE - 1) ? 0 : tb_v + 1;
        end else begin
            tb_h++;
        end
    endtask

    task automatic drive(input int nfr, input bit ramp, input int gap, input int stop_at);
        for (int b = 0; b < nfr * NB; b++) begin
            if (gap > 0)
                for (int g = 0; g < 8 && $urandom_range(99) < gap; g++) idle(1);
            beat(ramp);
            if (stop_at > 0 && out_q.size() >= stop_at) break;
        end
    endtask

    task automatic arm(input bit mode);
        i_mode  = mode;
        i_start = 1'b1;
        idle(3);
        i_start = 1'b0;
        idle(6);
    endtask

    task automatic clr();
        out_q.delete();
        src_q.delete();
        fd_cnt = 0; lat_err = 0; nz_err = 0;
    endtask

    task automatic check_out(input string tag, input logic [23:0] ev[3], input int es[3]);
        chk({tag, " count"}, out_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk({tag, " data"}, (i < out_q.size()) ? 32'(out_q[i]) : 32'hdeadbeef, 32'(ev[i % 3]));
            chk({tag, " src_h"}, (i < src_q.size()) ? src_q[i] : -1, es[i % 3]);
        end
        chk({tag, " frame_done"}, fd_cnt, 1);
        chk({tag, " latency"}, lat_err, 0);
        chk({tag, " idle_data"}, nz_err, 0);
        chk({tag, " busy_end"}, o_busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst o_de", o_de, 0);
        chk("rst o_data", o_data, 0);
        chk("rst o_busy", o_busy, 0);
        chk("rst o_frame_done", o_frame_done, 0);
        i_rst = 1'b0;
        idle(2);

        // average of a flat field: first frame only arms, second is transferred
        clr();
        arm(1'b1);
        chk("arm busy", o_busy, 1);
        drive(1, 1'b0, 0, 0);
        chk("wait frame silent", out_q.size(), 0);
        drive(1, 1'b0, 0, 0);
        idle(5);
        check_out("avg const", ev_const, es_avg);

        // decimate ramp; flipping i_mode after arming must not matter
        clr();
        arm(1'b0);
        i_mode = 1'b1;
        drive(2, 1'b1, 0, 0);
        idle(5);
        check_out("dec ramp", ev_ramp, es_dec);

        clr();
        arm(1'b1);
        drive(2, 1'b1, 0, 0);
        idle(5);
        check_out("avg ramp", ev_ramp, es_avg);

        clr();
        arm(1'b1);
        drive(2, 1'b0, 50, 0);
        idle(5);
        check_out("avg gaps", ev_const, es_avg);

        // start mid-frame arms for the next frame; start during TRAN is ignored
        clr();
        i_mode = 1'b1;
        fork
            drive(3, 1'b0, 0, 0);
            begin
                repeat (40) @(posedge i_clk);
                #1 i_start = 1'b1;
                repeat (3) @(posedge i_clk);
                #1 i_start = 1'b0;
                repeat (128) @(posedge i_clk);
                #1 i_start = 1'b1;
                repeat (3) @(posedge i_clk);
                #1 i_start = 1'b0;
            end
        join
        idle(5);
        check_out("start edges", ev_const, es_avg);

        // reset after the third output of a transfer
        clr();
        arm(1'b1);
        drive(2, 1'b0, 0, 3);
        i_rst = 1'b1;
        tb_h = 0; tb_v = 0;
        idle(2);
        chk("midrst busy", o_busy, 0);
        chk("midrst o_de", o_de, 0);
        i_rst = 1'b0;
        idle(2);
        drive(1, 1'b0, 0, 0);
        idle(5);
        chk("midrst out count", out_q.size(), 3);
        chk("midrst busy idle", o_busy, 0);
        chk("midrst no frame_done", fd_cnt, 0);
        clr();
        arm(1'b1);
        drive(2, 1'b0, 0, 0);
        idle(5);
        check_out("rearm", ev_const, es_avg);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/resize_box.md
Name: resize_box

Overview:
- Parametrised successor to the fixed 4:1 decimating video resizer in the camera-to-accelerator path.
- Crops a centred window from an active-video stream, then downscales it by 2^SCALE_LOG2 in both axes.
- Two run-time modes: decimation (top-left pixel of each block) and box averaging (mean of each block).
- Output is a valid-only pixel stream, one beat per output pixel, feeding the network input buffer.

Parameters:
- H_ACTIVE, 1920, input active pixels per line
- V_ACTIVE, 1080, input active lines per frame
- H_OUTPUT, 418, output pixels per line
- V_OUTPUT, 258, output lines per frame
- SCALE_LOG2, 2, log2 of the downscale factor per axis (S = 2^SCALE_LOG2)
- CH, 3, colour channels per pixel
- DW, 8, bits per channel
- OUT_SHIFT, 1, extra right shift applied to every output channel
- H_LEFT, (H_ACTIVE-(H_OUTPUT<<SCALE_LOG2))/2, first cropped column (derived)
- V_LEFT, (V_ACTIVE-(V_OUTPUT<<SCALE_LOG2))/2, first cropped line (derived)

Ports:
- i_clk  in  1  pixel clock
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  arm request; the rising edge counts, async-safe
- i_mode  in  1  0 = decimate, 1 = box average; latched on arm
- i_de  in  1  input pixel valid
- i_data  in  CH*DW  input pixel; channel 0 in the LSBs
- o_de  out  1  output pixel valid
- o_data  out  CH*DW  output pixel; same channel packing as i_data
- o_busy  out  1  high in WAIT and TRAN
- o_frame_done  out  1  one-cycle pulse when the transferred frame ends

Behaviour:
- Reset: state IDLE; all counters, accumulators, line memory write enable and outputs are 0.
- i_start: double-flop synchroniser, then rising-edge detect. Only edges are acted on, never levels.
- Counters h_cnt/v_cnt:
  - Free-running, advance only on i_de beats.
  - h_cnt wraps at H_ACTIVE-1; v_cnt increments on the h wrap and wraps at V_ACTIVE-1.
  - No beat counts while i_de is low; gaps of any length are allowed.
- FSM IDLE -> WAIT on the start edge; i_mode is latched here.
- FSM WAIT -> TRAN after the beat at (H_ACTIVE-1, V_ACTIVE-1). TRAN therefore always covers a complete frame.
- FSM TRAN -> IDLE after the beat at (H_ACTIVE-1, V_ACTIVE-1); o_frame_done pulses in that cycle+1.
- Start edges seen in WAIT or TRAN are ignored.
- Window: a beat is in-window when H_LEFT <= h_cnt < H_LEFT+H_OUTPUT*S and V_LEFT <= v_cnt < V_LEFT+V_OUTPUT*S.
- Sub-phase: hx = (h_cnt-H_LEFT) mod S and vy = (v_cnt-V_LEFT) mod S. Output column x = (h_cnt-H_LEFT)>>SCALE_LOG2.
- Decimate mode: in-window beat with hx==0 and vy==0 -> o_de=1, o_data = each channel >> OUT_SHIFT.
- Average mode:
  - Per-channel horizontal accumulator of width DW+SCALE_LOG2 sums the S beats of a block row.
  - On hx==S-1, the row sum goes to line memory[x]: written if vy==0, added if vy>0. Entries are DW+2*SCALE_LOG2 wide, H_OUTPUT deep, one per channel.
  - On hx==S-1 and vy==S-1, emit (memory[x]+row sum) >> (2*SCALE_LOG2+OUT_SHIFT), truncating.
- Latency: o_de/o_data appear exactly 2 cycles after the triggering input beat in both modes. The pipeline is not stalled by i_de gaps.
- Totals: exactly H_OUTPUT*V_OUTPUT o_de beats per TRAN frame; o_data is 0 whenever o_de is 0.
- Mode changes of i_mode outside the arm edge have no effect.
- Reset mid-TRAN: immediate return to IDLE with no further o_de. A new start edge is needed after release.
- Pipeline beats still in flight when TRAN ends are emitted normally.

Test Plan:
- Small params throughout: H_ACTIVE=16, V_ACTIVE=8, H_OUTPUT=3, V_OUTPUT=2, SCALE_LOG2=2, OUT_SHIFT=1, CH=3, DW=8. This gives H_LEFT=2, V_LEFT=0.
- Average, constant pixel 0x808080, start, two frames -> no output in frame 1. Frame 2 gives 6 beats of 0x404040, then one o_frame_done pulse.
- Decimate, R=G=B=h_cnt ramp -> each output line is 0x010101, 0x030303, 0x050505 (h=2,6,10). o_de is at 2-cycle latency.
- Average, same ramp -> block sums 56/120/184 give per-channel outputs 1, 3, 5. Confirms truncation and the 4-line accumulation.
- Random i_de gaps (about 50% duty), constant pixel -> same 6 outputs and values as gap-free. No extra or missing beats.
- i_start pulsed mid-frame and again during TRAN -> transfer starts only at the next frame. The second pulse is ignored and exactly one frame is processed.
- i_rst asserted after the 3rd output -> o_de stays 0 and o_busy=0. Start after release produces a full 6-beat frame.
